// File: rtl/cbfp_pkg.sv
// Shared sizing and bank-state definitions for the block-floating-point
// shift controller and its helpers.
package cbfp_pkg;

    localparam int DATA_WIDTH = 23;
    localparam int OUT_WIDTH  = 11;
    localparam int MAG_WIDTH  = 5;
    localparam int BEATS      = 4;
    localparam int LANES      = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY = 2'd0,
        BANK_FILL  = 2'd1,
        BANK_FULL  = 2'd2,
        BANK_DRAIN = 2'd3
    } bank_st_e;

endpackage

// File: rtl/cbfp_bank_max.sv
// Reduces the 16 per-lane leading-one indices of one beat to their maximum.
module cbfp_bank_max
    import cbfp_pkg::*;
#(
    parameter int MAG_WIDTH = cbfp_pkg::MAG_WIDTH
) (
    input  logic [LANES-1:0][MAG_WIDTH-1:0] idx_i,
    output logic [MAG_WIDTH-1:0]            max_o
);

    logic [MAG_WIDTH-1:0] m;

    always_comb begin
        m = '0;
        for (int l = 0; l < LANES; l++) begin
            if (idx_i[l] > m) m = idx_i[l];
        end
        max_o = m;
    end

endmodule

// File: rtl/cbfp_shift_ctrl.sv
// Ping-pong block buffer that finds each block's peak magnitude and emits
// the block scaled by a common right shift so every lane fits OUT_WIDTH.
module cbfp_shift_ctrl
    import cbfp_pkg::*;
#(
    parameter int DATA_WIDTH = cbfp_pkg::DATA_WIDTH,
    parameter int OUT_WIDTH  = cbfp_pkg::OUT_WIDTH,
    parameter int MAG_WIDTH  = cbfp_pkg::MAG_WIDTH,
    parameter int BEATS      = cbfp_pkg::BEATS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [LANES-1:0][DATA_WIDTH-1:0] din,
    output logic [LANES-1:0][DATA_WIDTH-1:0] mag_din,
    input  logic [LANES-1:0][MAG_WIDTH-1:0]  mag_idx,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [LANES-1:0][OUT_WIDTH-1:0]  dout,
    output logic [MAG_WIDTH-1:0]             out_exp,
    output logic                             out_first,
    output logic                             out_last
);

    localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;

    function automatic logic [MAG_WIDTH-1:0] calc_shift(input logic [MAG_WIDTH-1:0] m);
        if (int'(m) > OUT_WIDTH - 2) return MAG_WIDTH'(int'(m) - (OUT_WIDTH - 2));
        return '0;
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] scale(
        input logic signed [DATA_WIDTH-1:0] s,
        input logic [MAG_WIDTH-1:0]         sh
    );
        logic signed [DATA_WIDTH-1:0] t;
        t = s >>> sh;
        return t[OUT_WIDTH-1:0];
    endfunction

    bank_st_e             st_q [2];
    bank_st_e             st_d [2];
    logic                 wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [BW-1:0]        wr_beat_q, wr_beat_d, rd_beat_q, rd_beat_d;
    logic [MAG_WIDTH-1:0] max_q [2];
    logic [MAG_WIDTH-1:0] max_d [2];
    logic [MAG_WIDTH-1:0] exp_q [2];
    logic [MAG_WIDTH-1:0] exp_d [2];
    logic [LANES-1:0][DATA_WIDTH-1:0] mem_q [2][BEATS];

    logic                 in_fire, out_fire, wr_last, rd_last;
    logic [MAG_WIDTH-1:0] beat_max, run_max;

    assign mag_din   = din;
    assign in_ready  = (st_q[wr_ptr_q] == BANK_EMPTY) || (st_q[wr_ptr_q] == BANK_FILL);
    assign out_valid = (st_q[rd_ptr_q] == BANK_FULL) || (st_q[rd_ptr_q] == BANK_DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_last   = (wr_beat_q == BW'(BEATS - 1));
    assign rd_last   = (rd_beat_q == BW'(BEATS - 1));

    cbfp_bank_max #(.MAG_WIDTH(MAG_WIDTH)) u_bank_max (
        .idx_i (mag_idx),
        .max_o (beat_max)
    );

    // The first beat of a block restarts the running max.
    assign run_max = (wr_beat_q == '0) ? beat_max :
                     ((beat_max > max_q[wr_ptr_q]) ? beat_max : max_q[wr_ptr_q]);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        wr_beat_d = wr_beat_q;
        rd_beat_d = rd_beat_q;
        for (int b = 0; b < 2; b++) begin
            st_d[b]  = st_q[b];
            max_d[b] = max_q[b];
            exp_d[b] = exp_q[b];
            if (in_fire && (wr_ptr_q == 1'(b))) begin
                max_d[b] = run_max;
                if (wr_last) begin
                    st_d[b]  = BANK_FULL;
                    exp_d[b] = calc_shift(run_max);
                end else begin
                    st_d[b]  = BANK_FILL;
                end
            end
            if (out_fire && (rd_ptr_q == 1'(b))) begin
                st_d[b] = rd_last ? BANK_EMPTY : BANK_DRAIN;
            end
        end
        if (in_fire) begin
            wr_beat_d = wr_last ? '0 : wr_beat_q + 1'b1;
            if (wr_last) wr_ptr_d = ~wr_ptr_q;
        end
        if (out_fire) begin
            rd_beat_d = rd_last ? '0 : rd_beat_q + 1'b1;
            if (rd_last) rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q[0]   <= BANK_EMPTY;
            st_q[1]   <= BANK_EMPTY;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            wr_beat_q <= '0;
            rd_beat_q <= '0;
        end else begin
            st_q[0]   <= st_d[0];
            st_q[1]   <= st_d[1];
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_beat_q <= wr_beat_d;
            rd_beat_q <= rd_beat_d;
        end
    end

    // Sample storage and per-bank magnitude state are only meaningful once
    // the bank state says so, hence no reset here.
    always_ff @(posedge clk) begin
        max_q[0] <= max_d[0];
        max_q[1] <= max_d[1];
        exp_q[0] <= exp_d[0];
        exp_q[1] <= exp_d[1];
        if (in_fire) mem_q[wr_ptr_q][wr_beat_q] <= din;
    end

    always_comb begin
        dout      = '0;
        out_exp   = '0;
        out_first = 1'b0;
        out_last  = 1'b0;
        if (out_valid) begin
            for (int l = 0; l < LANES; l++) begin
                dout[l] = scale($signed(mem_q[rd_ptr_q][rd_beat_q][l]), exp_q[rd_ptr_q]);
            end
            out_exp   = exp_q[rd_ptr_q];
            out_first = (rd_beat_q == '0);
            out_last  = rd_last;
        end
    end

endmodule

// File: tb/tb_cbfp_shift_ctrl.sv
// Randomized bench for cbfp_shift_ctrl with a block-level reference model.
module tb_cbfp_shift_ctrl;

    localparam int DW = 23;
    localparam int OW = 11;
    localparam int MW = 5;
    localparam int NB = 4;
    localparam int NL = 16;

    typedef logic [NL-1:0][DW-1:0] beat_t;
    typedef struct packed {
        logic [NL-1:0][OW-1:0] d;
        logic [MW-1:0]         e;
        logic                  first;
        logic                  last;
    } obeat_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid, in_ready, out_valid, out_ready, out_first, out_last;
    logic [NL-1:0][DW-1:0] din, mag_din;
    logic [NL-1:0][MW-1:0] mag_idx;
    logic [NL-1:0][OW-1:0] dout;
    logic [MW-1:0]         out_exp;

    beat_t  in_q[$];
    beat_t  part_q[$];
    obeat_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int out_beats, first_out_cyc, last_out_cyc;
    bit saw_ir_low, captured;
    obeat_t cap;

    always #5 clk = ~clk;

    cbfp_shift_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din       (din),
        .mag_din   (mag_din),
        .mag_idx   (mag_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .out_exp   (out_exp),
        .out_first (out_first),
        .out_last  (out_last)
    );

    function automatic int lead1(input logic [DW-1:0] x);
        int a, idx;
        a = int'($signed(x));
        if (a < 0) a = -a;
        idx = 0;
        for (int b = 0; b < 32; b++) if (a[b]) idx = b;
        return idx;
    endfunction

    // External magnitude detector.
    always_comb begin
        for (int l = 0; l < NL; l++) mag_idx[l] = MW'(lead1(mag_din[l]));
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic beat_t fill(input int v);
        beat_t b;
        for (int l = 0; l < NL; l++) b[l] = DW'(v);
        return b;
    endfunction

    function automatic int rnd_sample();
        int w, v;
        w = $urandom_range(0, 22);
        v = int'($urandom_range(0, (1 << w) - 1));
        if ($urandom_range(0, 1) == 1) v = -v;
        if ($urandom_range(0, 199) == 0) v = -(1 << 22);
        return v;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        for (int l = 0; l < NL; l++) b[l] = DW'(rnd_sample());
        return b;
    endfunction

    // Reference: a completed block of NB beats yields NB scaled output beats.
    task automatic model_accept(input beat_t b);
        int m, sh;
        obeat_t o;
        part_q.push_back(b);
        if (part_q.size() == NB) begin
            m = 0;
            foreach (part_q[bt]) for (int l = 0; l < NL; l++) if (lead1(part_q[bt][l]) > m) m = lead1(part_q[bt][l]);
            sh = (m > OW - 2) ? m - (OW - 2) : 0;
            for (int bt = 0; bt < NB; bt++) begin
                for (int l = 0; l < NL; l++) o.d[l] = OW'(int'($signed(part_q[bt][l])) >>> sh);
                o.e     = MW'(sh);
                o.first = (bt == 0);
                o.last  = (bt == NB - 1);
                exp_q.push_back(o);
            end
            part_q.delete();
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = '0;
        rst       = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_exp", out_exp, 0);
        chk("rst_first_last", {out_first, out_last}, 0);
        chk("rst_dout_zero", |dout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        in_q.delete();
        part_q.delete();
        exp_q.delete();
    endtask

    task automatic run(input int valid_pct, input int ready_pct, input int stall, input int budget);
        int n;
        bit exp_ir;
        obeat_t e;
        n = 0;
        out_beats = 0;
        saw_ir_low = 0;
        captured = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
            in_valid  = (in_q.size() > 0) && ($urandom_range(0, 99) < valid_pct);
            din       = (in_q.size() > 0) ? in_q[0] : rnd_beat();
            out_ready = (n >= stall) && ($urandom_range(0, 99) < ready_pct);
            #1;
            exp_ir = (part_q.size() > 0) || (((exp_q.size() + NB - 1) / NB) < 2);
            chk("in_ready", in_ready, exp_ir);
            chk("out_valid", out_valid, exp_q.size() > 0);
            if (!in_ready) saw_ir_low = 1;
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                chk("out_exp", out_exp, e.e);
                chk("out_first", out_first, e.first);
                chk("out_last", out_last, e.last);
                for (int l = 0; l < NL; l++) chk($sformatf("dout[%0d]", l), $signed(dout[l]), $signed(e.d[l]));
                if (out_ready) begin
                    if (!captured) begin
                        cap.d = dout;
                        cap.e = out_exp;
                        cap.first = out_first;
                        cap.last = out_last;
                        captured = 1;
                        first_out_cyc = cyc;
                    end
                    last_out_cyc = cyc;
                    out_beats++;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) model_accept(in_q.pop_front());
            @(negedge clk);
            n++;
            cyc++;
        end
        chk("run_drained", in_q.size() + exp_q.size(), 0);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        beat_t b;
        do_reset();

        // All lanes 256: no shift.
        for (int i = 0; i < NB; i++) in_q.push_back(fill(256));
        run(100, 100, 0, 50);
        chk("t256_exp", cap.e, 0);
        chk("t256_lane7", $signed(cap.d[7]), 256);
        chk("t256_beats", out_beats, 4);

        // One full-scale negative lane forces a shift of 13.
        b = fill(1000);
        b[3] = DW'(-4194304);
        in_q.push_back(b);
        for (int i = 1; i < NB; i++) in_q.push_back(fill(1000));
        run(100, 100, 0, 50);
        chk("tneg_exp", cap.e, 13);
        chk("tneg_lane3", $signed(cap.d[3]), -512);
        chk("tneg_lane0", $signed(cap.d[0]), 0);

        // Peak 4096 -> shift 3; -5 floors to -1.
        b = fill(0);
        b[0] = DW'(4096);
        b[1] = DW'(-5);
        in_q.push_back(b);
        for (int i = 1; i < NB; i++) in_q.push_back(fill(0));
        run(100, 100, 0, 50);
        chk("t4096_exp", cap.e, 3);
        chk("t4096_lane0", $signed(cap.d[0]), 512);
        chk("t4096_lane1", $signed(cap.d[1]), -1);

        // All-zero block.
        for (int i = 0; i < NB; i++) in_q.push_back(fill(0));
        run(100, 100, 0, 50);
        chk("tzero_exp", cap.e, 0);

        // Three blocks back to back with a free-running sink.
        for (int i = 0; i < 3 * NB; i++) in_q.push_back(rnd_beat());
        run(100, 100, 0, 100);
        chk("b2b_beats", out_beats, 12);
        chk("b2b_contiguous", last_out_cyc - first_out_cyc + 1, 12);
        chk("b2b_ready_held", saw_ir_low, 0);

        // Same traffic against a 10-cycle sink stall.
        for (int i = 0; i < 3 * NB; i++) in_q.push_back(rnd_beat());
        run(100, 100, 10, 100);
        chk("stall_ready_drop", saw_ir_low, 1);
        chk("stall_beats", out_beats, 12);

        // Reset mid-block discards the partial block.
        for (int i = 0; i < 3; i++) in_q.push_back(rnd_beat());
        run(100, 100, 0, 50);
        do_reset();
        for (int i = 0; i < NB; i++) in_q.push_back(rnd_beat());
        run(100, 100, 0, 50);
        chk("post_rst_beats", out_beats, 4);

        // Random traffic with random valid/ready.
        for (int i = 0; i < 30 * NB; i++) in_q.push_back(rnd_beat());
        run(70, 60, 0, 3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbfp_shift_ctrl.md
CBFP_SHIFT_CTRL -- requirements
Module: cbfp_shift_ctrl

Interface
- REQ-001 SHALL take parameter DATA_WIDTH, default 23, as the signed input sample width.
- REQ-002 SHALL take parameter OUT_WIDTH, default 11, as the signed scaled output width.
- REQ-003 SHALL take parameter MAG_WIDTH, default 5, as the magnitude-index width.
- REQ-004 SHALL take parameter BEATS, default 4, as the number of 16-lane beats per block (64 samples).
- REQ-005 clk  in  1  single clock; all logic rising-edge.
- REQ-006 rst  in  1  asynchronous, active-high reset.
- REQ-007 in_valid  in  1  input beat valid.
- REQ-008 in_ready  out  1  input beat accepted when in_valid&&in_ready.
- REQ-009 din  in  16 x DATA_WIDTH signed  input lanes.
- REQ-010 mag_din  out  16 x DATA_WIDTH  combinational copy of din driven to the external magnitude detector.
- REQ-011 mag_idx  in  16 x MAG_WIDTH  leading-one index of |mag_din[i]|, same cycle; 0 for a zero sample.
- REQ-012 out_valid  out  1  output beat valid.
- REQ-013 out_ready  in  1  downstream accepts when out_valid&&out_ready.
- REQ-014 dout  out  16 x OUT_WIDTH signed  scaled lanes.
- REQ-015 out_exp  out  MAG_WIDTH  block shift amount, constant across a block.
- REQ-016 out_first / out_last  out  1 each  mark beat 0 / beat BEATS-1 of a block.

Function
- REQ-017 SHALL store blocks in two ping-pong banks of BEATS x 16 samples; each bank is in one of the states EMPTY, FILL, FULL or DRAIN.
- REQ-018 Bank transitions SHALL be: EMPTY->FILL on first accepted beat; FILL->FULL on BEATS-th accepted beat; FULL->DRAIN when selected for output; DRAIN->EMPTY on acceptance of the last beat.
- REQ-019 Write and read bank pointers SHALL each toggle after a complete block; block order SHALL be preserved.
- REQ-020 in_ready SHALL be 1 iff the write-pointer bank is EMPTY or FILL.
- REQ-021 Per bank, a running max of mag_idx over all accepted lanes SHALL be kept; it is cleared on the first beat of a block.
- REQ-022 The block shift SHALL be sh = max(M - (OUT_WIDTH-2), 0), where M is the block max index, latched when the bank enters FULL.
- REQ-023 dout[i] SHALL be the stored sample arithmetic-right-shifted by sh (floor), truncated to OUT_WIDTH; the result SHALL always fit.
- REQ-024 out_valid SHALL rise in the cycle after the last input beat of a block is accepted, when the read bank is FULL (1-cycle latency).
- REQ-025 Output beats SHALL be emitted in input order, one per cycle while out_ready=1.
- REQ-026 dout, out_exp, out_first and out_last SHALL hold stable while out_valid=1 and out_ready=0.
- REQ-027 With out_ready held at 1 and continuous input, in_ready SHALL stay 1 and throughput SHALL be 1 beat/cycle in and out.
- REQ-028 A bank freed by its last drain in cycle t SHALL be writable from cycle t+1; the same bank is never simultaneously written and read.
- REQ-029 An all-zero block SHALL give sh=0 and dout all zero.

Reset
- REQ-030 Reset SHALL set all banks EMPTY, both pointers and beat counters to 0, out_valid=0, out_first=0, out_last=0, out_exp=0, dout=0, and in_ready=1 immediately.
- REQ-031 Reset mid-block SHALL discard all partial and stored blocks; the first beat after reset is beat 0 of a new block.

Structure
- REQ-032 A shared cbfp_pkg SHALL hold DATA_WIDTH, OUT_WIDTH, MAG_WIDTH, BEATS, LANES=16 and the bank-state enum.
- REQ-033 One sub-module, cbfp_bank_max (a 16-lane max-of-index reducer), SHALL be used; the magnitude detector itself stays external.

Verification
- REQ-034 Reset asserted -> out_valid=0, in_ready=1, out_exp=0.
- REQ-035 4 beats, all lanes 256 (idx 8) -> out_exp=0, all dout=256, out_first on beat 0, out_last on beat 3, out_valid one cycle after the 4th input.
- REQ-036 One lane -4194304 (idx 22), others 1000 -> out_exp=13, that lane=-512, others=0.
- REQ-037 Max sample 4096 (idx 12), another lane -5 -> out_exp=3, 4096->512, -5->-1.
- REQ-038 3 blocks back-to-back, out_ready=1 -> in_ready never drops, 12 contiguous output beats; then out_ready=0 for 10 cycles -> in_ready drops after the 2nd block fills, no data lost or reordered.
- REQ-039 Reset pulsed after beat 2 of a block -> no output from that block; the next 4 beats form a correct block.
